psum_accumulator: RTL
=====================

# psum_accumulator

Downstream stage of the PE control FSM. It accumulates signed per-output-channel partial sums across input channels, using the FSM's `p_valid_output`, `last_chanel_output` and `end_conv` strobes together with the PE datapath's partial-sum bus. Each finished output-channel result is saturated and optionally ReLU-clipped, then pushed into a small output FIFO drained with a valid/ready handshake toward the output-feature-map writer.

## Interface
- `PSUM_W`, 16: width of the signed incoming partial sum.
- `ACC_W`, 24: width of the signed accumulator and result; must satisfy ACC_W ≥ PSUM_W+2.
- `FIFO_DEPTH`, 4: number of output FIFO entries; power of 2, ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cfg_co` in 2: number of output channels minus 1 (1..4 channels); sampled only in IDLE.
- `relu_en` in 1: clip negative results to 0; sampled only in IDLE.
- `p_valid` in 1: partial-sum strobe, driven by the FSM `p_valid_output`.
- `p_data` in PSUM_W: signed partial sum, valid while `p_valid` is high.
- `last_ch` in 1: qualifies `p_valid`; marks the final input channel (FSM `last_chanel_output`).
- `end_conv` in 1: end-of-convolution pulse from the FSM.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head this cycle.
- `out_data` out ACC_W: signed result at the FIFO head.
- `out_co` out 2: output-channel index of the head.
- `out_last` out 1: head is the final output channel (index = cfg_co).
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the drain completes.
- `err` out 1: sticky error flag.

## Operation
- **Storage:** bank `acc[0..3]` of ACC_W signed registers, plus channel pointer `co_ptr` (2 bits).
- **Latched config:** `cfg_co` and `relu_en` are latched on the IDLE→ACCUM transition.
- **Ordering:** the FSM emits partial sums channel-major: for each input channel, output channels 0..cfg_co in order.
- **FSM states:**
  - IDLE: `co_ptr`=0 and all acc=0. First `p_valid` → ACCUM. That beat is processed and `err` is cleared.
  - ACCUM: processes every `p_valid`. `end_conv` → DRAIN.
  - DRAIN: waits for the FIFO to empty. When empty, pulses `done` and goes to IDLE, clearing acc and `co_ptr`.
- **Beat with `p_valid`=1:**
  - sum = acc[co_ptr] + sign-extended `p_data`, saturated to the ACC_W signed range.
  - `co_ptr` advances by 1 and wraps to 0 after reaching the latched cfg_co.
- **Beat with `last_ch`=0:** acc[co_ptr] ← sum.
- **Beat with `last_ch`=1:**
  - result = (relu_en && sum<0) ? 0 : sum.
  - Pushes {result, co_ptr, co_ptr==cfg_co} to the FIFO and clears acc[co_ptr] to 0.
- **Push while full:** a push with FIFO full and no simultaneous pop is dropped and sets `err`. The acc entry is still cleared.
- **Stray `p_valid` in DRAIN:** ignored; sets `err`.
- **`end_conv` with `p_valid` in the same cycle:** the beat is processed first, then the state goes to DRAIN.
- **`end_conv` in IDLE:** goes to DRAIN. With the FIFO empty, `done` pulses the following cycle.
- **FIFO:**
  - Circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH).
  - Full = MSBs differ and LSBs equal. Empty = pointers equal.
  - Pop when `out_valid` && `out_ready`.
  - A simultaneous push and pop while full is legal: no drop.

## Timing
- **Reset values:** `out_valid`, `out_data`, `out_co`, `out_last`, `busy`, `done` and `err` are all 0; state IDLE; FIFO empty.
- **Throughput:** one `p_valid` beat accepted per cycle, no stalls. The block never back-pressures the FSM.
- **Push latency:** a pushed result appears with `out_valid`=1 in the cycle after the edge that sampled the `last_ch` beat (1-cycle latency).
- **Handshake:**
  - `out_data`, `out_co` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` depends only on FIFO state, never on `out_ready`.
- **`done`:** high exactly one cycle, in the cycle after the FIFO is observed empty in DRAIN. `busy` falls in the same cycle.
- **Reset mid-operation:** asynchronously clears the FSM, acc, `co_ptr`, FIFO pointers and `err`. Buffered results are discarded.

## Test plan
- **Two-channel accumulation:** cfg_co=2, relu_en=0, out_ready=1; p_data 10,20,30 with last_ch=0, then 1,2,3 with last_ch=1 → outputs 11/co0, 22/co1, 33/co2, with `out_last` only on co2. Then `end_conv` → one `done` pulse, `busy`=0.
- **ReLU:** cfg_co=0. With relu_en=1, feed -5 then -3 (last) → `out_data`=0. Repeat with relu_en=0 → `out_data`=-8 (0xFFFFF8).
- **Saturation:** ACC_W=18, cfg_co=0; 32767 ×4 with last_ch=0, then 32767 with last_ch=1 → `out_data`=131071, `err`=0. Repeat with -32768 ×5 → -131072.
- **Backpressure/overflow:** cfg_co=0, out_ready=0; five last_ch beats of 1..5 → 4 entries held, `err`=1. Raise out_ready → pops 1,2,3,4 and the FIFO is empty.
- **Full with simultaneous pop:** FIFO full, push with out_ready=1 in the same cycle → no drop, `err` stays 0, FIFO remains full.
- **Reset mid-run:** after 2 beats, pulse rst_n low → all outputs 0. A new run with 7 (last), cfg_co=0 → `out_data`=7.

Source files
------------

// File: rtl/psum_accumulator_if.sv
// psum_if: partial-sum strobes from the PE FSM and the result FIFO valid/ready handshake
interface psum_if #(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 24
);
    logic                     p_valid, last_ch, end_conv;
    logic signed [PSUM_W-1:0] p_data;
    logic                     out_valid, out_ready, out_last;
    logic signed [ACC_W-1:0]  out_data;
    logic [1:0]               out_co;
    modport master (output p_valid, p_data, last_ch, end_conv, out_ready,
                    input  out_valid, out_data, out_co, out_last);
    modport slave  (input  p_valid, p_data, last_ch, end_conv, out_ready,
                    output out_valid, out_data, out_co, out_last);
endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator: per-output-channel signed partial-sum accumulation with saturation,
// optional ReLU and a small result FIFO drained over valid/ready.
module psum_accumulator #(
    parameter int PSUM_W     = 16,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cfg_co_i,
    input  logic       relu_en_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    psum_if.slave      bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = ACC_W + 3;
    localparam logic signed [ACC_W-1:0] MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN = ~MAX;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] acc_d [4];
    logic [1:0]              co_q, co_d, cfg_q, cfg_d, cfg_eff;
    logic                    relu_q, relu_d, relu_eff, err_q, err_d, done_q, done_d;
    logic [EW-1:0]           mem_q [FIFO_DEPTH];
    logic [EW-1:0]           head;
    logic [AW:0]             wr_q, rd_q;
    logic signed [PSUM_W-1:0] pd;
    logic signed [ACC_W:0]   wide;
    logic signed [ACC_W-1:0] sum, result;
    logic                    beat, full, empty, pop, push_req, push;
    assign pd       = bus.p_data;
    // The first beat of a run uses the live config, since latching happens on that same edge
    assign cfg_eff  = (state_q == IDLE) ? cfg_co_i : cfg_q;
    assign relu_eff = (state_q == IDLE) ? relu_en_i : relu_q;
    assign beat     = bus.p_valid && state_q != DRAIN;
    assign wide     = (ACC_W+1)'(acc_q[co_q]) + (ACC_W+1)'(pd);
    assign sum      = (wide[ACC_W] != wide[ACC_W-1]) ? (wide[ACC_W] ? MIN : MAX) : wide[ACC_W-1:0];
    assign result   = (relu_eff && sum[ACC_W-1]) ? '0 : sum;
    assign empty    = wr_q == rd_q;
    assign full     = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    assign pop      = !empty && bus.out_ready;
    assign push_req = beat && bus.last_ch;
    assign push     = push_req && (!full || pop);
    always_comb begin
        acc_d   = acc_q;
        co_d    = co_q;
        cfg_d   = cfg_q;
        relu_d  = relu_q;
        err_d   = err_q;
        done_d  = 1'b0;
        state_d = (state_q == IDLE)  ? (bus.end_conv ? DRAIN : bus.p_valid ? ACCUM : IDLE) :
                  (state_q == ACCUM) ? (bus.end_conv ? DRAIN : ACCUM) :
                                       (empty ? IDLE : DRAIN);
        if (state_q == IDLE && bus.p_valid) begin
            cfg_d  = cfg_co_i;
            relu_d = relu_en_i;
            err_d  = 1'b0;
        end
        if (beat) begin
            acc_d[co_q] = bus.last_ch ? '0 : sum;
            co_d        = (co_q == cfg_eff) ? 2'd0 : co_q + 2'd1;
        end
        if ((push_req && !push) || (state_q == DRAIN && bus.p_valid))
            err_d = 1'b1;
        if (state_q == DRAIN && empty) begin
            acc_d  = '{default: '0};
            co_d   = 2'd0;
            done_d = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '{default: '0};
            co_q    <= '0;
            cfg_q   <= '0;
            relu_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            co_q    <= co_d;
            cfg_q   <= cfg_d;
            relu_q  <= relu_d;
            err_q   <= err_d;
            done_q  <= done_d;
            wr_q    <= wr_q + (AW+1)'(push);
            rd_q    <= rd_q + (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= {result, co_q, co_q == cfg_eff};
    end
    // Head fields are forced to zero while empty so reset and idle outputs read as 0
    assign head          = mem_q[rd_q[AW-1:0]];
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : head[EW-1:3];
    assign bus.out_co    = empty ? '0 : head[2:1];
    assign bus.out_last  = !empty && head[0];
    assign busy_o        = state_q != IDLE;
    assign done_o        = done_q;
    assign err_o         = err_q;
endmodule
